// File: rtl/param_shift_register_pkg.sv
// rtl/param_shift_register_pkg.sv - shared types and helpers for the universal shift register
//
// Purpose : operation codes, sequencer states, per-bit next-value selects and
//           the mode classification helpers used by the top and the bit cell.
// Ports   : none (package).
package shreg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Per-bit next-value source. LEFT takes the lower neighbour (shift towards
  // the MSB), RIGHT takes the upper neighbour (shift towards the LSB).
  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,
    SEL_LOAD  = 3'd1,
    SEL_LEFT  = 3'd2,
    SEL_RIGHT = 3'd3,
    SEL_ZERO  = 3'd4
  } sel_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Non-shift modes count as left so sout shows the MSB after load/clear/hold.
  function automatic logic dir_of(mode_t m);
    case (m)
      MODE_SHR, MODE_ROR, MODE_ASR: dir_of = DIR_RIGHT;
      default:                      dir_of = DIR_LEFT;
    endcase
  endfunction

  function automatic logic is_shift(mode_t m);
    case (m)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: is_shift = 1'b1;
      default:                                          is_shift = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/param_shift_register_if.sv
// rtl/param_shift_register_if.sv - request/data bundle of the universal shift register
//
// Purpose : groups the operation request, data and status signals.
// Signals : start, mode, count, D, sin (requester -> register);
//           Q, sout, busy, done (register -> requester).
// Modports: master = requester side, slave = shift register side.
interface param_shift_register_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] D;
  logic             sin;
  logic [WIDTH-1:0] Q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, count, D, sin,
    input  Q, sout, busy, done
  );

  modport slave (
    input  start, mode, count, D, sin,
    output Q, sout, busy, done
  );
endinterface

// File: rtl/param_shift_register_bit.sv
// rtl/param_shift_register_bit.sv - one storage bit with its next-value mux
//
// Purpose : selects hold/load/lower-neighbour/upper-neighbour/zero and registers it.
// Ports   : clk_i, rst_i (async, active-high), sel_i (next-value source),
//           load_i (parallel data bit), lower_i (bit shifted in on a left shift),
//           upper_i (bit shifted in on a right shift), q_o (stored bit).
module shreg_bit
  import shreg_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  sel_t sel_i,
  input  logic load_i,
  input  logic lower_i,
  input  logic upper_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (sel_i)
      SEL_LOAD:  q_d = load_i;
      SEL_LEFT:  q_d = lower_i;
      SEL_RIGHT: q_d = upper_i;
      SEL_ZERO:  q_d = 1'b0;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/param_shift_register.sv
// rtl/param_shift_register.sv - WIDTH-bit universal shift register with shift sequencer
//
// Purpose : hold/load/clear/shift/rotate/arithmetic-shift register; a start
//           request runs a captured number of shifts, one per clock.
// Ports   : clk (rising edge), R (async active-high reset),
//           bus (slave modport: start, mode, count, D, sin in; Q, sout, busy, done out).
module param_shift_register
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  R,
  param_shift_register_if.slave bus
);

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  mode_t            mode_q,  mode_d;
  logic             dir_q,   dir_d;

  sel_t             sel;
  mode_t            req_mode;
  logic             left_in;
  logic             right_in;
  logic [WIDTH-1:0] q_w;

  assign req_mode = mode_t'(bus.mode);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    sel     = SEL_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d  = req_mode;
          dir_d   = dir_of(req_mode);
          state_d = ST_DONE;
          if (is_shift(req_mode)) begin
            // Capture edge only arms the counter; shifting begins next edge.
            if (bus.count != '0) begin
              rem_d   = (bus.count > WIDTH_C) ? WIDTH_C : bus.count;
              state_d = ST_RUN;
            end
          end else if (req_mode == MODE_LOAD) begin
            sel = SEL_LOAD;
          end else if (req_mode == MODE_CLEAR) begin
            sel = SEL_ZERO;
          end
        end
      end
      ST_RUN: begin
        sel   = (dir_q == DIR_RIGHT) ? SEL_RIGHT : SEL_LEFT;
        rem_d = rem_q - ONE_C;
        if (rem_q == ONE_C) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bits entering at the ends of the register: serial input for logical
  // shifts, the opposite end for rotates, the sign bit for ASR.
  always_comb begin
    left_in  = bus.sin;
    right_in = bus.sin;
    if (mode_q == MODE_ROL) begin
      left_in = q_w[WIDTH-1];
    end
    case (mode_q)
      MODE_ROR: right_in = q_w[0];
      MODE_ASR: right_in = q_w[WIDTH-1];
      default:  right_in = bus.sin;
    endcase
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      mode_q  <= MODE_HOLD;
      dir_q   <= DIR_LEFT;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic lower;
    logic upper;
    if (i == 0) begin : g_lo
      assign lower = left_in;
    end else begin : g_lo
      assign lower = q_w[i-1];
    end
    if (i == WIDTH - 1) begin : g_hi
      assign upper = right_in;
    end else begin : g_hi
      assign upper = q_w[i+1];
    end
    shreg_bit u_bit (
      .clk_i   (clk),
      .rst_i   (R),
      .sel_i   (sel),
      .load_i  (bus.D[i]),
      .lower_i (lower),
      .upper_i (upper),
      .q_o     (q_w[i])
    );
  end

  assign bus.Q    = q_w;
  assign bus.sout = (dir_q == DIR_RIGHT) ? q_w[0] : q_w[WIDTH-1];
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);

endmodule

// File: doc/param_shift_register.md
Name: param_shift_register

Overview:
- Parametrised, WIDTH-bit universal shift register with a multi-cycle shift sequencer.
- Successor to the single-bit resettable master-slave flip-flop: one register bank provides hold, parallel load, clear, logical shifts, rotates and arithmetic shift right.
- A start/busy/done handshake executes a programmed number of shifts, one per clock.
- Used as the storage/serialisation element in datapath labs; RTL level, no gate delays.

Parameters:
- WIDTH, 8, register width in bits (>=2)
- CNT_W, $clog2(WIDTH+1), width of shift-count input

Ports:
- clk  input  1  clock, rising-edge active
- R  input  1  reset, asynchronous, active-high
- start  input  1  operation request; sampled only in IDLE
- mode  input  3  operation code; captured with start
- count  input  CNT_W  number of shifts; captured with start
- D  input  WIDTH  parallel load data; used with LOAD
- sin  input  1  serial input bit for SHL/SHR
- Q  output  WIDTH  register contents
- sout  output  1  serial output: Q[WIDTH-1] if captured direction is left, else Q[0]
- busy  output  1  high in RUN and DONE states
- done  output  1  one-cycle completion pulse, high in DONE only

Behaviour:
- Reset is asynchronous and active-high (R), with no clock required:
  - Q=0, state=IDLE, busy=0, done=0, remaining=0, dir=left, so sout=0.
  - Reset mid-RUN aborts the operation; no partial completion pulse.
- Mode codes:
  - 000 HOLD
  - 001 LOAD (Q<=D)
  - 010 SHL ({Q[W-2:0],sin})
  - 011 SHR ({sin,Q[W-1:1]})
  - 100 ROL
  - 101 ROR
  - 110 ASR ({Q[W-1],Q[W-1:1]})
  - 111 CLEAR (Q<=0)
- Direction: left for SHL/ROL and for HOLD/LOAD/CLEAR; right for SHR/ROR/ASR.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Mode, direction and count are captured.
  - HOLD/LOAD/CLEAR: the operation is applied at edge k, then state goes to DONE.
  - Shift modes with count=0: Q is unchanged and state goes to DONE.
  - Shift modes with count>0: remaining=min(count,WIDTH) and state goes to RUN.
- RUN:
  - Each edge performs one shift and decrements remaining.
  - The edge that performs the last shift moves state to DONE.
  - An n-shift operation changes Q at edges k+1..k+n; done is high for the cycle after edge k+n.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- start is ignored in RUN and DONE; a new start is accepted at the first IDLE edge. Back-to-back operations are therefore spaced by one IDLE cycle minimum.
- mode/count/D changes while busy have no effect, except that sin is sampled live every RUN edge.
- Count saturates at WIDTH for all shift modes. A rotate by WIDTH restores the original value.
- Q holds its value in IDLE.
- sout is combinational from Q and the captured direction.

Decomposition:
- Package shreg_pkg:
  - mode_t enum (8 codes above)
  - state_t enum (IDLE/RUN/DONE)
  - function dir_of(mode_t)
- Sub-module shreg_bit, instantiated WIDTH times:
  - Per-bit next-value mux (hold/load/left-neighbour/right-neighbour/zero) plus flip-flop with async active-high reset.
  - The top level holds the FSM, the remaining counter and the edge-bit (sin/rotate/sign) selection.

Test Plan (WIDTH=8, CNT_W=4):
- Reset: assert R mid-RUN between clock edges -> Q=0x00, busy=0, done=0 immediately; after release, next start is accepted normally.
- LOAD: start, mode=001, D=0xA5 -> Q=0xA5 after 1 edge; busy=1 and done=1 for exactly one cycle; sout=1.
- SHL: from 0xA5, start, mode=010, count=3, sin=1 -> Q=0x4B, 0x97, 0x2F on successive edges; busy high 4 cycles; done after 3rd shift; start pulsed during RUN is ignored.
- ROR: from 0x2F, count=8 -> Q=0x2F after 8 shifts. Then count=12 -> clamped to 8 shifts, Q=0x2F, done at cycle 9.
- ASR: load 0x96, start, mode=110, count=2 -> Q=0xCB then 0xE5; sout tracks Q[0] (1 then 1).
- Zero count: mode=011, count=0 -> Q unchanged, done after 1 edge. CLEAR from 0xFF -> Q=0x00 in 1 edge.
